dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage load/store requests.
- Replaces the single-cycle DataMemory with a valid/ready request channel, a fixed-latency access and a valid/ready response channel.
- Supports byte, half and word accesses, with load sign/zero extension and store byte-lane merge.
- The pipeline stalls on req_ready/resp_valid; that stall logic is outside this block.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of backing storage.
- LATENCY, 2: cycles from request accept to resp_valid assertion; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  load sign-extends when 1, zero-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  pipeline consumes the response
- resp_rdata  out  32  load data, extended; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal-size request

Behaviour:
- Reset values (rst low, async): state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, latency counter 0. Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch write/size/signed/addr/wdata, load counter with LATENCY-1, go to WAIT. If LATENCY=1, go directly to access and RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. When the counter reaches 0, perform the access that cycle and go to RESP.
  - RESP: resp_valid=1 and resp_rdata/resp_err stable until resp_valid&&resp_ready. Then return to IDLE, clearing resp_valid.
- Back-to-back requests: no new request is accepted in the handshake cycle. One access is outstanding at a time, so minimum spacing is LATENCY+1 cycles.
- Latency: accept edge at cycle N gives resp_valid visible after edge N+LATENCY.
- Byte lanes are little-endian: addr[1:0]=0 selects bits[7:0]; for halves, addr[1]=0 selects bits[15:0].
- Loads: extract the lane, then sign- or zero-extend per the latched signed bit. A word load ignores req_signed.
- Stores: merge only the addressed lanes into the word; the other bytes are unchanged. A store response has rdata=0.
- Error conditions:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH_WORDS.
- On error: no storage write, resp_err=1, resp_rdata=0.
- req_* inputs are ignored outside IDLE.
- Reset mid-operation: state returns to IDLE immediately. A store not yet performed (still in WAIT) is dropped. The pending response is discarded.
- resp_ready held high in RESP completes in one cycle. resp_ready asserted in IDLE/WAIT has no effect.

Optional Feature:
- Macro: DMEM_ERR_CAPTURE_EN.
- When defined, two extra outputs are added:
  - err_flag (1 bit): sticky. Sets on the first errored response and clears only on reset.
  - err_addr (32 bits): holds the req_addr of that first errored response. Later errors do not overwrite it.
  - Both reset to 0.
- When not defined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - FSM state encoding (IDLE/WAIT/RESP);
  - width constants, data width 32, LATENCY counter width 4.
- One natural sub-module, dmem_lane_align (combinational):
  - inputs: word, addr[1:0], size, signed, wdata;
  - outputs: extended load data, merged store word, misalign flag.

Test Plan:
- Reset, then store word 0xDEADBEEF at addr 0x10, then load word at 0x10 (LATENCY=2): resp_valid 2 cycles after each accept; rdata=0xDEADBEEF, err=0.
- After that word, load byte addr 0x13 signed, then unsigned: rdata=0xFFFFFFDE, then 0x000000DE.
- Store half 0x1234 at 0x12, then load word 0x10: rdata=0x1234BEEF.
- Load word at 0x11; store at addr 4*DEPTH_WORDS; size=11: each gives err=1 and rdata=0. A following load of 0x10 shows the word unchanged. With DMEM_ERR_CAPTURE_EN: err_addr=0x11 and err_flag=1.
- Hold resp_ready=0 for 5 cycles in RESP with req_valid=1: resp fields stable, req_ready=0, no second accept until 1 cycle after the response handshake.
- Store 0xAAAAAAAA at 0x20, assert rst low during WAIT, release, load 0x20: old contents returned, and resp_valid is 0 during and after the reset until the new request.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, size encodings and FSM states for the data-memory responder
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} sizeT;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: valid/ready request and response channels between pipeline and data memory
interface dmem_responder_if;
    import dmem_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane extraction/extension for loads and lane merge for stores
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addr,
    input  logic [1:0]        size,
    input  logic              isSigned,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] loadData,
    output logic [DATA_W-1:0] storeWord,
    output logic              misalign
);
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data;
    // pick the addressed lane, extend it, and merge store data into only the addressed bytes
    always_comb begin
        laneByte  = word[{addr, 3'b000} +: 8];
        laneHalf  = addr[1] ? word[31:16] : word[15:0];
        loadData  = size == SZ_WORD ? word
                  : size == SZ_HALF ? {{16{isSigned & laneHalf[15]}}, laneHalf}
                  : {{24{isSigned & laneByte[7]}}, laneByte};
        mask      = size == SZ_WORD ? 32'hFFFF_FFFF
                  : size == SZ_HALF ? (addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF)
                  : 32'h0000_00FF << {addr, 3'b000};
        data      = size == SZ_WORD ? wdata : size == SZ_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        storeWord = (word & ~mask) | (data & mask);
        misalign  = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder; DMEM_ERR_CAPTURE_EN adds sticky first-error capture
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
`ifdef DMEM_ERR_CAPTURE_EN
    ,
    output logic              err_flag,
    output logic [31:0]       err_addr
`endif
);
    localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic              reqReady, respValid, respErr;
    logic [DATA_W-1:0] respRdata;
    logic              latWrite, latSigned;
    logic [1:0]        latSize;
    logic [31:0]       latAddr;
    logic [DATA_W-1:0] latWdata;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              inIdle, accept, doAccess, aWrite, aSigned, aErr, misalign;
    logic [1:0]        aSize;
    logic [31:0]       aAddr;
    logic [DATA_W-1:0] aWdata, loadData, storeWord, accRdata;
    logic [IW-1:0]     idx;

    // with LATENCY=1 the access happens on the accept edge, so fields come straight from the bus in IDLE
    always_comb begin
        inIdle   = state == IDLE;
        accept   = bus.req_valid && reqReady;
        doAccess = (state == WAIT && cnt == '0) || (LATENCY == 1 && inIdle && accept);
        aWrite   = inIdle ? bus.req_write : latWrite;
        aSize    = inIdle ? bus.req_size : latSize;
        aSigned  = inIdle ? bus.req_signed : latSigned;
        aAddr    = inIdle ? bus.req_addr : latAddr;
        aWdata   = inIdle ? bus.req_wdata : latWdata;
        idx      = aAddr[IW+1:2];
        aErr     = aSize == SZ_ILL || misalign || ({2'b00, aAddr[31:2]} >= 32'(DEPTH_WORDS));
        accRdata = (aErr || aWrite) ? '0 : loadData;
    end

    dmem_lane_align u_align (
        .word      (mem[idx]),
        .addr      (aAddr[1:0]),
        .size      (aSize),
        .isSigned  (aSigned),
        .wdata     (aWdata),
        .loadData  (loadData),
        .storeWord (storeWord),
        .misalign  (misalign)
    );

    // backing storage is not reset; only error-free stores write, never while reset is asserted
    always_ff @(posedge clk)
        if (rst && doAccess && aWrite && !aErr) mem[idx] <= storeWord;

    // request/wait/response sequencing with registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            reqReady  <= 1'b1;
            respValid <= 1'b0;
            respRdata <= '0;
            respErr   <= 1'b0;
            latWrite  <= 1'b0;
            latSize   <= SZ_BYTE;
            latSigned <= 1'b0;
            latAddr   <= '0;
            latWdata  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    latWrite  <= bus.req_write;
                    latSize   <= bus.req_size;
                    latSigned <= bus.req_signed;
                    latAddr   <= bus.req_addr;
                    latWdata  <= bus.req_wdata;
                    cnt       <= CNT_W'(LATENCY - 1);
                    reqReady  <= 1'b0;
                    if (LATENCY == 1) begin
                        respValid <= 1'b1;
                        respRdata <= accRdata;
                        respErr   <= aErr;
                        state     <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == '0) begin
                    respValid <= 1'b1;
                    respRdata <= accRdata;
                    respErr   <= aErr;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (bus.resp_ready) begin
                    respValid <= 1'b0;
                    respRdata <= '0;
                    respErr   <= 1'b0;
                    reqReady  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.resp_valid = respValid;
    assign bus.resp_rdata = respRdata;
    assign bus.resp_err   = respErr;

`ifdef DMEM_ERR_CAPTURE_EN
    // remember only the first errored access address until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else if (doAccess && aErr && !err_flag) begin
            err_flag <= 1'b1;
            err_addr <= aAddr;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with a response scoreboard checked by an independent monitor
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prevValid = 1'b0;
    expT  expQ[$];

    dmem_responder_if bus ();
`ifdef DMEM_ERR_CAPTURE_EN
    logic        err_flag;
    logic [31:0] err_addr;
`endif

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_ERR_CAPTURE_EN
        ,
        .err_flag (err_flag),
        .err_addr (err_addr)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // monitor: compare every presented response against the scoreboard head, pop on handshake
    always @(negedge clk) begin
        if (rst && bus.resp_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %h err %b required no response", bus.resp_rdata, bus.resp_err);
            end else begin
                if (!prevValid) chk("latency", 32'(cyc), 32'(expQ[0].cyc + LAT));
                chk("rdata", bus.resp_rdata, expQ[0].rdata);
                chk("err", 32'(bus.resp_err), 32'(expQ[0].err));
                if (bus.resp_ready) void'(expQ.pop_front());
            end
        end
        prevValid = rst && bus.resp_valid;
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee, input bit push);
        int t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got req_ready 0 required 1");
        end
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        if (push) expQ.push_back('{ed, ee, cyc + 1});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((expQ.size() != 0 || bus.resp_valid) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", expQ.size());
        end
    endtask

    task automatic xfer(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        issue(w, sz, sg, a, wd, ed, ee, 1'b1);
        drain();
    endtask

    initial begin
        int t;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
`ifdef DMEM_ERR_CAPTURE_EN
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
`endif
        rst = 1'b1;

        xfer(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        xfer(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        xfer(0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
        xfer(0, 2'b00, 0, 32'h13, 32'h0, 32'h000000DE, 0);
        xfer(1, 2'b01, 0, 32'h12, 32'h0000_1234, 32'h0, 0);
        xfer(0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0);
        xfer(0, 2'b01, 1, 32'h12, 32'h0, 32'h00001234, 0);
        xfer(0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
        xfer(0, 2'b01, 0, 32'h10, 32'h0, 32'h0000BEEF, 0);
        xfer(0, 2'b00, 1, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
        xfer(1, 2'b00, 0, 32'h11, 32'hFFFF_FF55, 32'h0, 0);
        xfer(0, 2'b10, 1, 32'h10, 32'h0, 32'h123455EF, 0);

        xfer(0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1);
        xfer(1, 2'b10, 0, 32'(4 * DEPTH), 32'h5555_5555, 32'h0, 1);
        xfer(1, 2'b11, 0, 32'h10, 32'h5555_5555, 32'h0, 1);
        xfer(1, 2'b01, 0, 32'h13, 32'h5555_5555, 32'h0, 1);
        xfer(1, 2'b10, 0, 32'h12, 32'h5555_5555, 32'h0, 1);
        xfer(0, 2'b10, 0, 32'h10, 32'h0, 32'h123455EF, 0);
`ifdef DMEM_ERR_CAPTURE_EN
        chk("err_flag", 32'(err_flag), 32'd1);
        chk("err_addr", err_addr, 32'h11);
`endif

        bus.resp_ready = 1'b0;
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h123455EF, 0, 1'b1);
        @(negedge clk);
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b10;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h0;
        bus.req_valid  = 1'b1;
        t = 0;
        while (!bus.resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("stall_resp_seen", 32'(bus.resp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
        chk("post_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
        expQ.push_back('{32'h0, 1'b0, cyc + 1});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("held_req_accepted", 32'(bus.req_ready), 32'd0);
        drain();
        xfer(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0);

        xfer(1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0);
        xfer(0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0);
        issue(1, 2'b10, 0, 32'h20, 32'hAAAAAAAA, 32'h0, 0, 1'b0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        xfer(0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
